// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wr_arbiter
// Purpose  : Two-source (ALU / load) writeback FIFOs arbitrated onto the
//            register bank write port. Define ARB_FIXED_PRIO_EN for fixed B priority.
// Revision : 1.0
// ============================================================================
module regfile_wr_arbiter #(
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   a_valid,
   output logic                   a_ready,
   input  logic [ADDR_W-1:0]      a_dir,
   input  logic [DATA_W-1:0]      a_data,
   input  logic                   b_valid,
   output logic                   b_ready,
   input  logic [ADDR_W-1:0]      b_dir,
   input  logic [DATA_W-1:0]      b_data,
   output logic                   wr_en,
   output logic [ADDR_W-1:0]      wr_dir,
   output logic [DATA_W-1:0]      wr_data,
   output logic [2**ADDR_W-1:0]   pend_mask,
   output logic                   idle
);

   localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_cnt_w = c_ptr_w + 1;

   // Index 0 is source A, index 1 is source B throughout.
   logic [ADDR_W-1:0]   r_dir_mem  [2][FIFO_DEPTH];
   logic [DATA_W-1:0]   r_data_mem [2][FIFO_DEPTH];
   logic [c_ptr_w-1:0]  r_wp  [2];
   logic [c_ptr_w-1:0]  r_rp  [2];
   logic [c_cnt_w-1:0]  r_cnt [2];

   logic [ADDR_W-1:0]   w_in_dir  [2];
   logic [DATA_W-1:0]   w_in_data [2];
   logic [1:0]          w_valid;
   logic [1:0]          w_ne;
   logic [1:0]          w_full;
   logic [1:0]          w_push;
   logic [1:0]          w_pop;
   logic                w_grant;
   logic                w_grant_b;
   logic [ADDR_W-1:0]   w_head_dir;
   logic [DATA_W-1:0]   w_head_data;
   logic [2**ADDR_W-1:0] w_pend;
   logic [c_ptr_w-1:0]  w_off;

   logic                r_wr_en;
   logic [ADDR_W-1:0]   r_wr_dir;
   logic [DATA_W-1:0]   r_wr_data;

   assign w_in_dir[0]  = a_dir;
   assign w_in_dir[1]  = b_dir;
   assign w_in_data[0] = a_data;
   assign w_in_data[1] = b_data;
   assign w_valid      = {b_valid, a_valid};

   for (genvar s = 0; s < 2; s++) begin : g_src
      assign w_ne[s]   = (r_cnt[s] != '0);
      assign w_full[s] = (r_cnt[s] == c_cnt_w'(FIFO_DEPTH));
   end

   // Ready comes from registered occupancy only, never from this cycle's pop.
   assign a_ready = ~w_full[0];
   assign b_ready = ~w_full[1];
   assign w_push  = w_valid & ~w_full & {2{~flush}};

`ifdef ARB_FIXED_PRIO_EN
   assign w_grant_b = w_ne[1];
`else
   logic r_ptr_b;

   assign w_grant_b = w_ne[1] & (~w_ne[0] | r_ptr_b);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_ptr_b <= 1'b0;
      else if (flush)
         r_ptr_b <= 1'b0;
      else if (&w_ne)
         r_ptr_b <= ~w_grant_b;
   end
`endif

   assign w_grant     = |w_ne;
   assign w_pop       = {w_grant_b, w_ne[0] & ~w_grant_b} & {2{~flush}};
   assign w_head_dir  = w_grant_b ? r_dir_mem[1][r_rp[1]]  : r_dir_mem[0][r_rp[0]];
   assign w_head_data = w_grant_b ? r_data_mem[1][r_rp[1]] : r_data_mem[0][r_rp[0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < 2; s++) begin
            r_wp[s]  <= '0;
            r_rp[s]  <= '0;
            r_cnt[s] <= '0;
         end
      end else if (flush) begin
         for (int s = 0; s < 2; s++) begin
            r_wp[s]  <= '0;
            r_rp[s]  <= '0;
            r_cnt[s] <= '0;
         end
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (w_push[s])
               r_wp[s] <= r_wp[s] + c_ptr_w'(1);
            if (w_pop[s])
               r_rp[s] <= r_rp[s] + c_ptr_w'(1);
            if (w_push[s] && !w_pop[s])
               r_cnt[s] <= r_cnt[s] + c_cnt_w'(1);
            else if (!w_push[s] && w_pop[s])
               r_cnt[s] <= r_cnt[s] - c_cnt_w'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (w_push[s]) begin
            r_dir_mem[s][r_wp[s]]  <= w_in_dir[s];
            r_data_mem[s][r_wp[s]] <= w_in_data[s];
         end
      end
   end

   // Writes to register 0 are consumed but never strobe the bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_en   <= 1'b0;
         r_wr_dir  <= '0;
         r_wr_data <= '0;
      end else if (flush) begin
         r_wr_en   <= 1'b0;
      end else if (w_grant) begin
         r_wr_en   <= |w_head_dir;
         r_wr_dir  <= w_head_dir;
         r_wr_data <= w_head_data;
      end else begin
         r_wr_en   <= 1'b0;
      end
   end

   always_comb begin
      w_pend = '0;
      w_off  = '0;
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            w_off = c_ptr_w'(i) - r_rp[s];
            if ({1'b0, w_off} < r_cnt[s])
               w_pend[r_dir_mem[s][i]] = 1'b1;
         end
      end
      w_pend[0] = 1'b0;
   end

   assign wr_en     = r_wr_en;
   assign wr_dir    = r_wr_dir;
   assign wr_data   = r_wr_data;
   assign pend_mask = w_pend;
   assign idle      = ~(|w_ne) & ~r_wr_en;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wr_arbiter
// Purpose  : Directed self-checking bench for regfile_wr_arbiter.
// Revision : 1.0
// ============================================================================
module tb_regfile_wr_arbiter;

   localparam int DEPTH = 4;
   localparam int DW    = 32;
   localparam int AW    = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          a_valid = 1'b0;
   logic          b_valid = 1'b0;
   logic [AW-1:0] a_dir = '0;
   logic [AW-1:0] b_dir = '0;
   logic [DW-1:0] a_data = '0;
   logic [DW-1:0] b_data = '0;
   logic          a_ready, b_ready, wr_en, idle;
   logic [AW-1:0] wr_dir;
   logic [DW-1:0] wr_data;
   logic [31:0]   pend_mask;

   int total = 0;
   int bad   = 0;
   logic [AW+DW-1:0] iss_q[$];

   regfile_wr_arbiter #(.FIFO_DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .a_valid(a_valid), .a_ready(a_ready), .a_dir(a_dir), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_dir(b_dir), .b_data(b_data),
      .wr_en(wr_en), .wr_dir(wr_dir), .wr_data(wr_data),
      .pend_mask(pend_mask), .idle(idle)
   );

   always #5 clk = ~clk;

   // Log every write that actually strobes the bank.
   always @(negedge clk)
      if (rst_n && wr_en) iss_q.push_back({wr_dir, wr_data});

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (!idle && n < bound) begin
         step();
         n++;
      end
      total++;
      if (idle !== 1'b1) begin
         bad++;
         $display("FAIL wait_idle: idle=%b required 1 within %0d cycles", idle, bound);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (wr_en !== 1'b0)    begin bad++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
      total++; if (wr_dir !== '0)     begin bad++; $display("FAIL reset_wr_dir: got %0d want 0", wr_dir); end
      total++; if (wr_data !== '0)    begin bad++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
      total++; if (pend_mask !== '0)  begin bad++; $display("FAIL reset_pend: got %h want 0", pend_mask); end
      total++; if (idle !== 1'b1)     begin bad++; $display("FAIL reset_idle: got %b want 1", idle); end
      rst_n = 1'b1;
      step();
      total++; if (a_ready !== 1'b1)  begin bad++; $display("FAIL reset_a_ready: got %b want 1", a_ready); end
      total++; if (b_ready !== 1'b1)  begin bad++; $display("FAIL reset_b_ready: got %b want 1", b_ready); end
   endtask

   task automatic test_single();
      a_valid = 1'b1; a_dir = 5'd5; a_data = 32'h0000_00AA;
      step();
      a_valid = 1'b0;
      total++; if (wr_en !== 1'b0)         begin bad++; $display("FAIL single_lat1_wr_en: got %b want 0", wr_en); end
      total++; if (pend_mask !== 32'h20)   begin bad++; $display("FAIL single_pend: got %h want 00000020", pend_mask); end
      total++; if (idle !== 1'b0)          begin bad++; $display("FAIL single_busy: got %b want 0", idle); end
      step();
      total++; if (wr_en !== 1'b1)         begin bad++; $display("FAIL single_wr_en: got %b want 1", wr_en); end
      total++; if (wr_dir !== 5'd5)        begin bad++; $display("FAIL single_wr_dir: got %0d want 5", wr_dir); end
      total++; if (wr_data !== 32'hAA)     begin bad++; $display("FAIL single_wr_data: got %h want 000000aa", wr_data); end
      total++; if (pend_mask !== '0)       begin bad++; $display("FAIL single_pend_clear: got %h want 0", pend_mask); end
      step();
      total++; if (wr_en !== 1'b0)         begin bad++; $display("FAIL single_wr_en_off: got %b want 0", wr_en); end
      total++; if (idle !== 1'b1)          begin bad++; $display("FAIL single_idle: got %b want 1", idle); end
   endtask

   task automatic test_interleave();
      int ia = 0, ib = 0, cyc = 0;
      bit acc_a, acc_b;
      logic [AW+DW-1:0] exp_v, got_v;
      do_flush();
      iss_q.delete();
      while ((ia < 8 || ib < 8) && cyc < 100) begin
         a_valid = (ia < 8); a_dir = AW'(1 + ia); a_data = DW'(32'h100 + ia);
         b_valid = (ib < 8); b_dir = AW'(9 + ib); b_data = DW'(32'h200 + ib);
         acc_a = a_valid && a_ready;
         acc_b = b_valid && b_ready;
         step();
         if (acc_a) ia++;
         if (acc_b) ib++;
         cyc++;
      end
      a_valid = 1'b0; b_valid = 1'b0;
      wait_idle(60);
      total++; if (iss_q.size() != 16) begin bad++; $display("FAIL interleave_count: got %0d want 16", iss_q.size()); end
      for (int k = 0; k < 16; k++) begin
`ifdef ARB_FIXED_PRIO_EN
         if (k < 8) exp_v = {AW'(9 + k), DW'(32'h200 + k)};
         else       exp_v = {AW'(1 + k - 8), DW'(32'h100 + k - 8)};
`else
         if (k % 2 == 0) exp_v = {AW'(1 + k / 2), DW'(32'h100 + k / 2)};
         else            exp_v = {AW'(9 + k / 2), DW'(32'h200 + k / 2)};
`endif
         got_v = (k < iss_q.size()) ? iss_q[k] : 'x;
         total++;
         if (got_v !== exp_v) begin
            bad++;
            $display("FAIL interleave_order[%0d]: got %h want %h", k, got_v, exp_v);
         end
      end
   endtask

   task automatic test_fill();
      int ia = 0, ib = 0, cyc = 0, stall_at = -1, na = 0, nb = 0;
      bit acc_a, acc_b;
      logic [AW-1:0] d;
      logic [DW-1:0] v;
      do_flush();
      iss_q.delete();
      while ((ia < 8 || ib < 12) && cyc < 200) begin
         a_valid = (ia < 8);  a_dir = AW'(17 + ia); a_data = DW'(32'h400 + ia);
         b_valid = (ib < 12); b_dir = 5'd30;        b_data = DW'(32'h300 + ib);
         if (a_valid && !a_ready && stall_at < 0) stall_at = ia;
         acc_a = a_valid && a_ready;
         acc_b = b_valid && b_ready;
         step();
         if (acc_a) ia++;
         if (acc_b) ib++;
         cyc++;
      end
      a_valid = 1'b0; b_valid = 1'b0;
      total++; if (ia != 8 || ib != 12) begin bad++; $display("FAIL fill_accept: got a=%0d b=%0d want a=8 b=12", ia, ib); end
`ifdef ARB_FIXED_PRIO_EN
      total++; if (stall_at != 4) begin bad++; $display("FAIL fill_stall_point: got %0d want 4", stall_at); end
`else
      total++; if (stall_at != 7) begin bad++; $display("FAIL fill_stall_point: got %0d want 7", stall_at); end
`endif
      wait_idle(100);
      for (int k = 0; k < iss_q.size(); k++) begin
         {d, v} = iss_q[k];
         if (d == 5'd30) begin
            total++;
            if (v !== DW'(32'h300 + nb)) begin bad++; $display("FAIL fill_b_order[%0d]: got %h want %h", nb, v, DW'(32'h300 + nb)); end
            nb++;
         end else begin
            total++;
            if ({d, v} !== {AW'(17 + na), DW'(32'h400 + na)}) begin
               bad++; $display("FAIL fill_a_order[%0d]: got %0d/%h want %0d/%h", na, d, v, 17 + na, 32'h400 + na);
            end
            na++;
         end
      end
      total++; if (na != 8 || nb != 12) begin bad++; $display("FAIL fill_issued: got a=%0d b=%0d want a=8 b=12", na, nb); end
   endtask

   task automatic test_reg0();
      do_flush();
      iss_q.delete();
      b_valid = 1'b1; b_dir = 5'd0; b_data = 32'hDEAD_BEEF;
      step();
      b_valid = 1'b0;
      total++; if (pend_mask !== '0)          begin bad++; $display("FAIL reg0_pend_q: got %h want 0", pend_mask); end
      total++; if (idle !== 1'b0)             begin bad++; $display("FAIL reg0_queued: got idle=%b want 0", idle); end
      step();
      total++; if (wr_en !== 1'b0)            begin bad++; $display("FAIL reg0_wr_en: got %b want 0", wr_en); end
      total++; if (wr_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL reg0_wr_data: got %h want deadbeef", wr_data); end
      total++; if (wr_dir !== 5'd0)           begin bad++; $display("FAIL reg0_wr_dir: got %0d want 0", wr_dir); end
      total++; if (idle !== 1'b1)             begin bad++; $display("FAIL reg0_popped: got idle=%b want 1", idle); end
      step();
      total++; if (iss_q.size() != 0)         begin bad++; $display("FAIL reg0_no_write: got %0d writes want 0", iss_q.size()); end
   endtask

   task automatic test_flush();
      logic [AW+DW-1:0] got_v;
      do_flush();
      iss_q.delete();
      for (int k = 0; k < 3; k++) begin
         a_valid = 1'b1;    a_dir = AW'(1 + k);  a_data = DW'(32'h500 + k);
         b_valid = (k < 2); b_dir = AW'(10 + k); b_data = DW'(32'h600 + k);
         step();
      end
      a_valid = 1'b0; b_valid = 1'b0;
      total++; if (pend_mask !== 32'h0000_080C) begin bad++; $display("FAIL flush_pend_before: got %h want 0000080c", pend_mask); end
      total++; if (wr_en !== 1'b1)              begin bad++; $display("FAIL flush_wr_before: got %b want 1", wr_en); end
      flush = 1'b1; a_valid = 1'b1; a_dir = 5'd7; a_data = 32'h5FF;
      step();
      flush = 1'b0; a_valid = 1'b0;
      total++; if (wr_en !== 1'b0)     begin bad++; $display("FAIL flush_wr_en: got %b want 0", wr_en); end
      total++; if (pend_mask !== '0)   begin bad++; $display("FAIL flush_pend: got %h want 0", pend_mask); end
      total++; if (idle !== 1'b1)      begin bad++; $display("FAIL flush_idle: got %b want 1", idle); end
      total++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin bad++; $display("FAIL flush_ready: got a=%b b=%b want 1 1", a_ready, b_ready); end
      repeat (4) step();
      total++; if (iss_q.size() != 2)  begin bad++; $display("FAIL flush_count: got %0d want 2", iss_q.size()); end
      got_v = (iss_q.size() > 0) ? iss_q[0] : 'x;
      total++; if (got_v !== {5'd1, 32'h500})  begin bad++; $display("FAIL flush_first: got %h want %h", got_v, {5'd1, 32'h500}); end
      got_v = (iss_q.size() > 1) ? iss_q[1] : 'x;
      total++; if (got_v !== {5'd10, 32'h600}) begin bad++; $display("FAIL flush_second: got %h want %h", got_v, {5'd10, 32'h600}); end
   endtask

   task automatic test_async_reset();
      do_flush();
      for (int k = 0; k < 3; k++) begin
         a_valid = 1'b1; a_dir = AW'(20 + k); a_data = DW'(32'h700 + k);
         b_valid = 1'b1; b_dir = AW'(25 + k); b_data = DW'(32'h800 + k);
         step();
      end
      a_valid = 1'b0; b_valid = 1'b0;
      total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL arst_busy: got %b want 1", wr_en); end
      #2;
      rst_n = 1'b0;
      #1;
      iss_q.delete();
      total++; if (wr_en !== 1'b0)    begin bad++; $display("FAIL arst_wr_en: got %b want 0", wr_en); end
      total++; if (wr_dir !== '0)     begin bad++; $display("FAIL arst_wr_dir: got %0d want 0", wr_dir); end
      total++; if (wr_data !== '0)    begin bad++; $display("FAIL arst_wr_data: got %h want 0", wr_data); end
      total++; if (pend_mask !== '0)  begin bad++; $display("FAIL arst_pend: got %h want 0", pend_mask); end
      total++; if (idle !== 1'b1)     begin bad++; $display("FAIL arst_idle: got %b want 1", idle); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      a_valid = 1'b1; a_dir = 5'd12; a_data = 32'h777;
      total++; if (a_ready !== 1'b1)  begin bad++; $display("FAIL arst_ready: got %b want 1", a_ready); end
      step();
      a_valid = 1'b0;
      total++; if (wr_en !== 1'b0 || pend_mask !== 32'h1000) begin bad++; $display("FAIL arst_post_q: got wr_en=%b pend=%h want 0 00001000", wr_en, pend_mask); end
      step();
      total++; if ({wr_en, wr_dir, wr_data} !== {1'b1, 5'd12, 32'h777}) begin bad++; $display("FAIL arst_post_issue: got %b/%0d/%h want 1/12/00000777", wr_en, wr_dir, wr_data); end
      repeat (3) step();
      total++; if (iss_q.size() != 1) begin bad++; $display("FAIL arst_no_stale: got %0d writes want 1", iss_q.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_interleave();
      test_fill();
      test_reg0();
      test_flush();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
